// File: rtl/final_soc_nios2_qsys_0_jtag_debug_module_ocimem.sv
// rtl/final_soc_nios2_qsys_0_jtag_debug_module_ocimem.sv - debug monitor RAM shared by JTAG commands and CPU Avalon-MM port
module final_soc_nios2_qsys_0_jtag_debug_module_ocimem #(
    parameter int AW         = 8,
    parameter bit INIT_READY = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [37:0]   jdo,
    input  logic          take_action_ocimem_a,
    input  logic          take_action_ocimem_b,
    input  logic          take_no_action_ocimem_a,
    input  logic [AW-1:0] avs_address,
    input  logic          avs_read,
    input  logic          avs_write,
    input  logic [31:0]   avs_writedata,
    input  logic [3:0]    avs_byteenable,
    output logic [31:0]   avs_readdata,
    output logic          avs_readdatavalid,
    output logic          avs_waitrequest,
    output logic [31:0]   MonDReg,
    output logic          monitor_ready,
    output logic          monitor_error
);

    typedef enum logic [1:0] {IDLE, PEND_RD, RD_DATA, PEND_WR} state_t;

    state_t        state;
    logic [AW-1:0] mon_a;
    logic [31:0]   wr_data;
    logic          no_inc;
    logic [31:0]   ram_q;
    logic [31:0]   mem [2**AW];

    logic cpu_busy, cpu_rd;
    logic cmd_a, cmd_b, cmd_n, any_cmd;
    logic jtag_rd_issue, jtag_wr_issue;
    logic [AW-1:0] ram_addr;
    logic unused_jdo;

    assign cpu_busy = avs_read | avs_write;
    assign cpu_rd   = avs_read & ~avs_write;

    assign cmd_a   = take_action_ocimem_a;
    assign cmd_b   = take_action_ocimem_b & ~take_action_ocimem_a;
    assign cmd_n   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign any_cmd = cmd_a | cmd_b | cmd_n;

    // JTAG only touches the RAM in cycles the CPU leaves free
    assign jtag_rd_issue = (state == PEND_RD) && !cpu_busy;
    assign jtag_wr_issue = (state == PEND_WR) && !cpu_busy && !reset;
    assign ram_addr      = cpu_busy ? avs_address : mon_a;

    assign avs_waitrequest = 1'b0;
    assign avs_readdata    = ram_q;
    assign unused_jdo      = ^{jdo[37:35], jdo[2:0]};

    always_ff @(posedge clk) begin
        if (avs_write) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_byteenable[b])
                    mem[avs_address][b*8 +: 8] <= avs_writedata[b*8 +: 8];
            end
        end else if (jtag_wr_issue) begin
            mem[mon_a] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_q             <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= cpu_rd;
            if (cpu_rd || jtag_rd_issue)
                ram_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mon_a         <= '0;
            wr_data       <= '0;
            no_inc        <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= INIT_READY;
            monitor_error <= 1'b0;
        end else begin
            if (any_cmd && state != IDLE)
                monitor_error <= 1'b1;
            // an explicit clear beats a drop detected in the same cycle
            if (cmd_a && jdo[25])
                monitor_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_a) begin
                        mon_a <= jdo[17 +: AW];
                        if (jdo[34]) begin
                            state         <= PEND_RD;
                            no_inc        <= 1'b1;
                            monitor_ready <= 1'b0;
                        end
                    end else if (cmd_b) begin
                        wr_data       <= jdo[34:3];
                        state         <= PEND_WR;
                        monitor_ready <= 1'b0;
                    end else if (cmd_n) begin
                        state         <= PEND_RD;
                        no_inc        <= 1'b0;
                        monitor_ready <= 1'b0;
                    end
                end
                PEND_RD: begin
                    if (!cpu_busy)
                        state <= RD_DATA;
                end
                RD_DATA: begin
                    MonDReg <= ram_q;
                    if (!no_inc)
                        mon_a <= mon_a + 1'b1;
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                PEND_WR: begin
                    if (!cpu_busy) begin
                        mon_a         <= mon_a + 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_final_soc_nios2_qsys_0_jtag_debug_module_ocimem.sv
// tb/tb_final_soc_nios2_qsys_0_jtag_debug_module_ocimem.sv - directed bench for the debug monitor RAM
module tb_final_soc_nios2_qsys_0_jtag_debug_module_ocimem;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid, avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int passed = 0;
    int total  = 0;
    int cyc;
    int n_valid;

    final_soc_nios2_qsys_0_jtag_debug_module_ocimem #(.AW(8), .INIT_READY(1'b1)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_readdatavalid       (avs_readdatavalid),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] addr, input bit rd, input bit clr);
        logic [37:0] v;
        v = '0;
        v[24:17] = addr;
        v[34]    = rd;
        v[25]    = clr;
        return v;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        return {3'b000, data, 3'b000};
    endfunction

    task automatic strobe_a(input logic [7:0] addr, input bit rd, input bit clr);
        jdo = mk_a(addr, rd, clr);
        take_action_ocimem_a = 1'b1;
        step();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [31:0] data);
        jdo = mk_b(data);
        take_action_ocimem_b = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic strobe_n();
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!monitor_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("ready_timeout", 32'(monitor_ready), 32'd1);
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        avs_address    = addr;
        avs_writedata  = data;
        avs_byteenable = be;
        avs_write      = 1'b1;
        step();
        avs_write = 1'b0;
    endtask

    task automatic cpu_read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        avs_address = addr;
        avs_read    = 1'b1;
        step();
        avs_read = 1'b0;
        check({tag, "_valid"}, 32'(avs_readdatavalid), 32'd1);
        check(tag, avs_readdata, exp);
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        avs_byteenable = 4'hF;
        step();
        step();
        reset = 1'b0;
        check("rst_mondreg", MonDReg, 32'h0);
        check("rst_ready", 32'(monitor_ready), 32'd1);
        check("rst_error", 32'(monitor_error), 32'd0);
        check("rst_rvalid", 32'(avs_readdatavalid), 32'd0);
        check("rst_rdata", avs_readdata, 32'h0);
        check("waitrequest", 32'(avs_waitrequest), 32'd0);

        // JTAG write then readback
        strobe_a(8'h10, 1'b0, 1'b0);
        check("addr_only_ready", 32'(monitor_ready), 32'd1);
        strobe_b(32'hDEADBEEF);
        check("wr_busy", 32'(monitor_ready), 32'd0);
        wait_ready(cyc);
        check("wr_latency", 32'(cyc), 32'd1);
        strobe_a(8'h10, 1'b1, 1'b0);
        check("rd_busy1", 32'(monitor_ready), 32'd0);
        step();
        check("rd_busy2", 32'(monitor_ready), 32'd0);
        step();
        check("rd_ready3", 32'(monitor_ready), 32'd1);
        check("rd_data", MonDReg, 32'hDEADBEEF);
        cpu_read_check("cpu_rd_10", 8'h10, 32'hDEADBEEF);
        step();
        check("rvalid_single", 32'(avs_readdatavalid), 32'd0);

        // auto-increment and wrap
        cpu_write(8'hFF, 32'hA5A50FF0, 4'hF);
        cpu_write(8'h00, 32'h12345678, 4'hF);
        strobe_a(8'hFF, 1'b0, 1'b0);
        strobe_n();
        wait_ready(cyc);
        check("inc_latency", 32'(cyc), 32'd2);
        check("rd_ff", MonDReg, 32'hA5A50FF0);
        strobe_n();
        wait_ready(cyc);
        check("rd_wrap_00", MonDReg, 32'h12345678);
        strobe_b(32'h0F0F1234);
        wait_ready(cyc);
        cpu_read_check("wr_at_01", 8'h01, 32'h0F0F1234);

        // CPU contention: JTAG read stalls while CPU reads
        n_valid = 0;
        avs_address = 8'h00;
        avs_read = 1'b1;
        strobe_a(8'h10, 1'b1, 1'b0);
        n_valid += int'(avs_readdatavalid);
        for (int i = 0; i < 4; i++) begin
            step();
            n_valid += int'(avs_readdatavalid);
        end
        check("cont_stall", 32'(monitor_ready), 32'd0);
        avs_read = 1'b0;
        step();
        n_valid += int'(avs_readdatavalid);
        check("cont_after1", 32'(monitor_ready), 32'd0);
        step();
        n_valid += int'(avs_readdatavalid);
        check("cont_after2", 32'(monitor_ready), 32'd1);
        check("cont_pulses", 32'(n_valid), 32'd5);
        check("cont_data", MonDReg, 32'hDEADBEEF);

        // busy collision
        cpu_write(8'h20, 32'h0BADF00D, 4'hF);
        cpu_write(8'h21, 32'h55555555, 4'hF);
        avs_address = 8'h30;
        avs_read = 1'b1;
        strobe_a(8'h20, 1'b1, 1'b0);
        strobe_b(32'hCAFECAFE);
        check("coll_error", 32'(monitor_error), 32'd1);
        avs_read = 1'b0;
        wait_ready(cyc);
        check("coll_latency", 32'(cyc), 32'd2);
        check("coll_rd_data", MonDReg, 32'h0BADF00D);
        cpu_read_check("coll_ram20", 8'h20, 32'h0BADF00D);
        cpu_read_check("coll_ram21", 8'h21, 32'h55555555);
        check("coll_sticky", 32'(monitor_error), 32'd1);
        strobe_a(8'h00, 1'b0, 1'b1);
        check("coll_clear", 32'(monitor_error), 32'd0);

        // CPU byte write
        cpu_write(8'h40, 32'h11223344, 4'hF);
        cpu_write(8'h40, 32'h0000AB00, 4'b0010);
        strobe_a(8'h40, 1'b1, 1'b0);
        wait_ready(cyc);
        check("byte_jtag", MonDReg, 32'h1122AB44);
        cpu_read_check("byte_cpu", 8'h40, 32'h1122AB44);

        // simultaneous read and write: write wins, no valid
        avs_address = 8'h50;
        avs_writedata = 32'h00000077;
        avs_byteenable = 4'hF;
        avs_read = 1'b1;
        avs_write = 1'b1;
        step();
        avs_read = 1'b0;
        avs_write = 1'b0;
        check("rw_no_valid", 32'(avs_readdatavalid), 32'd0);
        cpu_read_check("rw_write_won", 8'h50, 32'h00000077);

        // reset while a JTAG write is pending
        cpu_write(8'h60, 32'h00000000, 4'hF);
        strobe_a(8'h60, 1'b0, 1'b0);
        avs_address = 8'h61;
        avs_read = 1'b1;
        strobe_b(32'h99999999);
        reset = 1'b1;
        avs_read = 1'b0;
        step();
        reset = 1'b0;
        check("midrst_ready", 32'(monitor_ready), 32'd1);
        check("midrst_mondreg", MonDReg, 32'h0);
        step();
        cpu_read_check("midrst_nowrite", 8'h60, 32'h00000000);
        strobe_n();
        wait_ready(cyc);
        check("midrst_addr0", MonDReg, 32'h12345678);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
